// File: rtl/getir_paket.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : getir_paket                                               |
// | Purpose  : Shared constants and entry type for the fetch buffer.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package getir_paket;

  // Default widths of one stored instruction and its PC
  localparam int BUYRUK_W = 32;
  localparam int PS_W     = 32;

  // Instruction presented to decode while the buffer is empty (addi x0,x0,0)
  localparam logic [BUYRUK_W-1:0] NOP_BUYRUK = 32'h0000_0013;

  // One buffer entry at the default widths: PC in the upper half
  typedef struct packed {
    logic [PS_W-1:0]     ps;
    logic [BUYRUK_W-1:0] buyruk;
  } giris_t;

endpackage
`default_nettype wire

// File: rtl/getir_tamponu_bellek.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : getir_tamponu_bellek                                      |
// | Purpose  : Entry storage for the fetch buffer. GIRIS_SAYISI write    |
// |            lanes with their own enable and slot index, one           |
// |            combinational read port.                                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module getir_tamponu_bellek #(
  parameter int DERINLIK     = 8,
  parameter int GIRIS_SAYISI = 4,
  parameter int BUYRUK_W     = 32,
  parameter int PS_W         = 32,
  parameter int ADR_W        = $clog2(DERINLIK)
) (
  input  logic                                 clk,
  input  logic [GIRIS_SAYISI-1:0]              yaz_en,
  input  logic [GIRIS_SAYISI-1:0][ADR_W-1:0]   yaz_adr,
  input  logic [GIRIS_SAYISI-1:0][BUYRUK_W-1:0] yaz_buyruk,
  input  logic [GIRIS_SAYISI-1:0][PS_W-1:0]    yaz_ps,
  input  logic [ADR_W-1:0]                     oku_adr,
  output logic [BUYRUK_W-1:0]                  oku_buyruk,
  output logic [PS_W-1:0]                      oku_ps
);

  logic [BUYRUK_W-1:0] buyruk_dizi [DERINLIK];
  logic [PS_W-1:0]     ps_dizi     [DERINLIK];

  // Lane writes; the top guarantees the enabled lanes target distinct slots
  always_ff @(posedge clk) begin
    for (int k = 0; k < GIRIS_SAYISI; k++) begin
      if (yaz_en[k]) begin
        buyruk_dizi[yaz_adr[k]] <= yaz_buyruk[k];
        ps_dizi[yaz_adr[k]]     <= yaz_ps[k];
      end
    end
  end

  // Asynchronous read of the head slot
  assign oku_buyruk = buyruk_dizi[oku_adr];
  assign oku_ps     = ps_dizi[oku_adr];

endmodule
`default_nettype wire

// File: rtl/getir_tamponu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : getir_tamponu                                             |
// | Purpose  : Fetch buffer between the I-cache controller and decode.   |
// |            Multi-lane push with per-entry PC, single-entry pop with  |
// |            first-word fall-through, one-cycle flush on redirect.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module getir_tamponu
  import getir_paket::*;
#(
  parameter int DERINLIK     = 8,
  parameter int GIRIS_SAYISI = 4,
  parameter int BUYRUK_W     = getir_paket::BUYRUK_W,
  parameter int PS_W         = getir_paket::PS_W
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                yaz_gecerli_i,
  input  logic [PS_W-1:0]                     yaz_ps_i,
  input  logic [GIRIS_SAYISI*BUYRUK_W-1:0]    yaz_obek_i,
  input  logic [$clog2(GIRIS_SAYISI+1)-1:0]   yaz_sayi_i,
  output logic                                yaz_hazir_o,
  input  logic                                temizle_i,
  input  logic                                oku_hazir_i,
  output logic                                buyruk_gecerli_o,
  output logic [BUYRUK_W-1:0]                 buyruk_o,
  output logic [PS_W-1:0]                     ps_o,
  output logic [$clog2(DERINLIK+1)-1:0]       doluluk_o
);

  localparam int ADR_W  = $clog2(DERINLIK);
  localparam int CNT_W  = $clog2(DERINLIK+1);
  localparam int SAYI_W = $clog2(GIRIS_SAYISI+1);

  logic [ADR_W-1:0] yaz_ptr;
  logic [ADR_W-1:0] oku_ptr;
  logic [CNT_W-1:0] doluluk;
  logic [CNT_W-1:0] doluluk_sonraki;
  logic [CNT_W-1:0] bos_yer;
  logic             bos;
  logic             yaz_kabul;
  logic             oku_kabul;

  logic [GIRIS_SAYISI-1:0]               serit_en;
  logic [GIRIS_SAYISI-1:0][ADR_W-1:0]    serit_adr;
  logic [GIRIS_SAYISI-1:0][BUYRUK_W-1:0] serit_buyruk;
  logic [GIRIS_SAYISI-1:0][PS_W-1:0]     serit_ps;
  logic [BUYRUK_W-1:0]                   bas_buyruk;
  logic [PS_W-1:0]                       bas_ps;

  // Handshake: both sides depend only on registered state plus the request lines
  assign bos         = (doluluk == '0);
  assign bos_yer     = CNT_W'(DERINLIK) - doluluk;
  assign yaz_hazir_o = (bos_yer >= CNT_W'(GIRIS_SAYISI));
  // Reset cycles drop pushes exactly like a flush does
  assign yaz_kabul   = yaz_gecerli_i & yaz_hazir_o & ~temizle_i & rst_i
                       & (yaz_sayi_i != '0);
  assign oku_kabul   = buyruk_gecerli_o & oku_hazir_i & ~temizle_i;

  // Per-lane write controls: lane k goes to yaz_ptr+k with PC yaz_ps_i+4k
  generate
    for (genvar k = 0; k < GIRIS_SAYISI; k++) begin : g_serit
      assign serit_en[k]     = yaz_kabul && (SAYI_W'(k) < yaz_sayi_i);
      assign serit_adr[k]    = yaz_ptr + ADR_W'(k);
      assign serit_buyruk[k] = yaz_obek_i[k*BUYRUK_W +: BUYRUK_W];
      assign serit_ps[k]     = yaz_ps_i + PS_W'(4*k);
    end
  endgenerate

  getir_tamponu_bellek #(
    .DERINLIK     (DERINLIK),
    .GIRIS_SAYISI (GIRIS_SAYISI),
    .BUYRUK_W     (BUYRUK_W),
    .PS_W         (PS_W),
    .ADR_W        (ADR_W)
  ) u_bellek (
    .clk        (clk_i),
    .yaz_en     (serit_en),
    .yaz_adr    (serit_adr),
    .yaz_buyruk (serit_buyruk),
    .yaz_ps     (serit_ps),
    .oku_adr    (oku_ptr),
    .oku_buyruk (bas_buyruk),
    .oku_ps     (bas_ps)
  );

  // Occupancy after this cycle's accepted push and pop
  always_comb begin
    doluluk_sonraki = doluluk;
    if (yaz_kabul) doluluk_sonraki = doluluk_sonraki + CNT_W'(yaz_sayi_i);
    if (oku_kabul) doluluk_sonraki = doluluk_sonraki - CNT_W'(1);
  end

  // Pointer and count registers; reset and flush both empty the buffer
  always_ff @(posedge clk_i) begin
    if (!rst_i || temizle_i) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      doluluk <= '0;
    end else begin
      if (yaz_kabul) yaz_ptr <= yaz_ptr + ADR_W'(yaz_sayi_i);
      if (oku_kabul) oku_ptr <= oku_ptr + ADR_W'(1);
      doluluk <= doluluk_sonraki;
    end
  end

  // Head outputs fall through from storage; an empty buffer shows a NOP at PC 0
  assign buyruk_gecerli_o = ~bos;
  assign buyruk_o         = bos ? BUYRUK_W'(NOP_BUYRUK) : bas_buyruk;
  assign ps_o             = bos ? '0 : bas_ps;
  assign doluluk_o        = doluluk;

endmodule
`default_nettype wire
